// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data RAM arbiter: access codes and response-owner encoding.
package mem_arbiter_pkg;
    localparam logic [2:0] ACC_B  = 3'b000;
    localparam logic [2:0] ACC_H  = 3'b001;
    localparam logic [2:0] ACC_W  = 3'b010;
    localparam logic [2:0] ACC_BU = 3'b100;
    localparam logic [2:0] ACC_HU = 3'b101;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;
endpackage

// File: rtl/mem_align_chk.sv
// Combinational legality screen: access code plus low address bits -> legal flag.
module mem_align_chk
    import mem_arbiter_pkg::*;
(
    input  logic [2:0] i_access,
    input  logic [1:0] i_addr_lo,
    output logic       o_legal
);
    always_comb begin
        o_legal = 1'b0;
        case (i_access)
            ACC_B, ACC_BU: o_legal = 1'b1;
            ACC_H, ACC_HU: o_legal = ~i_addr_lo[0];
            ACC_W:         o_legal = (i_addr_lo == 2'b00);
            default:       o_legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store, with a one-cycle
// registered response routed back to the granted requester and fetch starvation bound.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_access,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              ram_load,
    output logic              ram_store,
    output logic [2:0]        ram_access,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);

    logic          w_if_legal, w_d_legal;
    logic          w_if_win, w_d_win, w_any_gnt, w_bad, w_load;
    logic [SW-1:0] r_starve;
    logic          r_resp_valid, r_resp_err, r_resp_is_load;
    owner_e        r_resp_owner;

    mem_align_chk u_if_chk (
        .i_access  (ACC_W),
        .i_addr_lo (if_addr[1:0]),
        .o_legal   (w_if_legal)
    );

    mem_align_chk u_d_chk (
        .i_access  (d_access),
        .i_addr_lo (d_addr[1:0]),
        .o_legal   (w_d_legal)
    );

    // Data has priority unless fetch has been held off for STARVE_MAX cycles.
    // Gating with rstn keeps every strobe low while reset is asserted.
    always_comb begin
        w_if_win  = rstn && if_req && (!d_req || r_starve == C_STARVE_MAX);
        w_d_win   = rstn && d_req && !w_if_win;
        w_any_gnt = w_if_win || w_d_win;
        w_bad     = w_if_win ? !w_if_legal : !w_d_legal;
        w_load    = w_if_win ? 1'b1 : !d_we;
    end

    assign if_gnt     = w_if_win;
    assign d_gnt      = w_d_win;
    assign ram_load   = w_any_gnt && !w_bad && w_load;
    assign ram_store  = w_d_win && w_d_legal && d_we;
    assign ram_access = w_if_win ? ACC_W : d_access;
    assign ram_addr   = w_if_win ? if_addr : d_addr;
    assign ram_wdata  = d_wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve <= '0;
        end else if (!if_req || w_if_win) begin
            r_starve <= '0;
        end else if (w_d_win && r_starve != C_STARVE_MAX) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_resp_valid   <= 1'b0;
            r_resp_owner   <= OWN_IF;
            r_resp_err     <= 1'b0;
            r_resp_is_load <= 1'b0;
        end else begin
            r_resp_valid <= w_any_gnt;
            if (w_any_gnt) begin
                r_resp_owner   <= w_if_win ? OWN_IF : OWN_D;
                r_resp_err     <= w_bad;
                r_resp_is_load <= w_load;
            end
        end
    end

    // RAM data is only forwarded for a legal load; stores and errors return zero.
    always_comb begin
        if_rvalid = r_resp_valid && (r_resp_owner == OWN_IF);
        d_rvalid  = r_resp_valid && (r_resp_owner == OWN_D);
        if_err    = if_rvalid && r_resp_err;
        d_err     = d_rvalid && r_resp_err;
        if_rdata  = (if_rvalid && r_resp_is_load && !r_resp_err) ? ram_rdata : 32'h0;
        d_rdata   = (d_rvalid && r_resp_is_load && !r_resp_err) ? ram_rdata : 32'h0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed RAM model that extends loads itself.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [2:0]  d_access;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        ram_load, ram_store;
    logic [2:0]  ram_access;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:255];

    mem_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_access(d_access), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .ram_load(ram_load), .ram_store(ram_store), .ram_access(ram_access),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_rd(input logic [7:0] a, input logic [2:0] acc);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a];
        b1 = mem[a + 8'd1];
        b2 = mem[a + 8'd2];
        b3 = mem[a + 8'd3];
        case (acc)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always @(posedge clk) begin
        logic [7:0] a;
        a = ram_addr[7:0];
        if (ram_store) begin
            mem[a] = ram_wdata[7:0];
            if (ram_access[1:0] != 2'b00) mem[a + 8'd1] = ram_wdata[15:8];
            if (ram_access[1:0] == 2'b10) begin
                mem[a + 8'd2] = ram_wdata[23:16];
                mem[a + 8'd3] = ram_wdata[31:24];
            end
        end
        if (ram_load) ram_rdata <= ram_rd(a, ram_access);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_set(input logic we, input logic [2:0] acc, input logic [31:0] a,
                         input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_access = acc; d_addr = a; d_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hEF; mem[8'h11] = 8'hBE; mem[8'h12] = 8'hAD; mem[8'h13] = 8'hDE;
        rstn = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_access = 3'b010; d_addr = 32'h0; d_wdata = 32'h0;
        #2;
        chk("rst_gnt", {30'h0, if_gnt, d_gnt}, 32'h0);
        chk("rst_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
        chk("rst_strobes", {30'h0, ram_load, ram_store}, 32'h0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // reset while a grant is pending and while a response is visible
        d_set(1'b0, 3'b010, 32'h10, 32'h0);
        #1;
        chk("r1_gnt_pre", {31'h0, d_gnt}, 32'h1);
        tick();
        chk("r1_rvalid_pre", {31'h0, d_rvalid}, 32'h1);
        rstn = 1'b0;
        #1;
        chk("r1_gnt_in_rst", {30'h0, if_gnt, d_gnt}, 32'h0);
        chk("r1_load_in_rst", {30'h0, ram_load, ram_store}, 32'h0);
        chk("r1_rvalid_in_rst", {31'h0, d_rvalid}, 32'h0);
        chk("r1_rdata_in_rst", d_rdata, 32'h0);
        d_req = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("r1_no_rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);

        // fetch alone
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk("f_gnt", {30'h0, if_gnt, d_gnt}, 32'h2);
        chk("f_ram", {ram_addr[27:0], ram_access, ram_load}, {28'h10, 3'b010, 1'b1});
        tick();
        if_req = 1'b0;
        #1;
        chk("f_rvalid", {29'h0, if_rvalid, if_err, d_rvalid}, 32'h4);
        chk("f_rdata", if_rdata, 32'hDEADBEEF);
        tick();
        chk("f_rvalid_off", {31'h0, if_rvalid}, 32'h0);

        // misaligned fetch
        if_req = 1'b1; if_addr = 32'h12;
        #1;
        chk("fm_gnt_noload", {30'h0, if_gnt, ram_load}, 32'h2);
        tick();
        if_req = 1'b0;
        chk("fm_err", {30'h0, if_rvalid, if_err}, 32'h3);
        chk("fm_rdata", if_rdata, 32'h0);
        tick();

        // contention: data wins 4 cycles, then fetch is forced through once
        if_req = 1'b1; if_addr = 32'h10;
        d_set(1'b0, 3'b010, 32'h10, 32'h0);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("cont_c%0d", c), {30'h0, if_gnt, d_gnt},
                (c == 4) ? 32'h2 : 32'h1);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // store word, then load byte unsigned from its top byte
        d_set(1'b1, 3'b010, 32'h20, 32'h12345678);
        #1;
        chk("sw_strobes", {29'h0, d_gnt, ram_load, ram_store}, 32'h5);
        tick();
        d_set(1'b0, 3'b100, 32'h23, 32'h0);
        chk("sw_resp", {30'h0, d_rvalid, d_err}, 32'h2);
        chk("sw_rdata", d_rdata, 32'h0);
        #1;
        chk("lbu_gnt", {31'h0, d_gnt}, 32'h1);
        tick();
        d_req = 1'b0;
        chk("lbu_rvalid", {31'h0, d_rvalid}, 32'h1);
        chk("lbu_rdata", d_rdata, 32'h00000012);
        tick();

        // misaligned word load
        d_set(1'b0, 3'b010, 32'h22, 32'h0);
        #1;
        chk("lwm_gnt_noload", {30'h0, d_gnt, ram_load}, 32'h2);
        tick();
        d_req = 1'b0;
        chk("lwm_err", {30'h0, d_rvalid, d_err}, 32'h3);
        chk("lwm_rdata", d_rdata, 32'h0);
        tick();

        // illegal access code
        d_set(1'b0, 3'b011, 32'h20, 32'h0);
        #1;
        chk("ill_gnt_noload", {30'h0, d_gnt, ram_load}, 32'h2);
        tick();
        d_req = 1'b0;
        chk("ill_err", {30'h0, d_rvalid, d_err}, 32'h3);
        tick();

        // back-to-back LB then LH
        d_set(1'b0, 3'b000, 32'h20, 32'h0);
        tick();
        d_set(1'b0, 3'b001, 32'h20, 32'h0);
        chk("b2b_lb_rvalid", {31'h0, d_rvalid}, 32'h1);
        chk("b2b_lb_rdata", d_rdata, 32'h00000078);
        #1;
        chk("b2b_lh_gnt", {31'h0, d_gnt}, 32'h1);
        tick();
        d_req = 1'b0;
        chk("b2b_lh_rvalid", {31'h0, d_rvalid}, 32'h1);
        chk("b2b_lh_rdata", d_rdata, 32'h00005678);
        tick();
        chk("b2b_idle", {31'h0, d_rvalid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
